// File: rtl/rv32_ctrl_pkg.sv
// rv32_ctrl_pkg: opcodes, ALU/imm/writeback codes and the decoded control word
package rv32_ctrl_pkg;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    localparam logic [4:0] ALU_ADD   = 5'd0;
    localparam logic [4:0] ALU_SUB   = 5'd1;
    localparam logic [4:0] ALU_SLL   = 5'd2;
    localparam logic [4:0] ALU_SLT   = 5'd3;
    localparam logic [4:0] ALU_SLTU  = 5'd4;
    localparam logic [4:0] ALU_XOR   = 5'd5;
    localparam logic [4:0] ALU_SRL   = 5'd6;
    localparam logic [4:0] ALU_SRA   = 5'd7;
    localparam logic [4:0] ALU_OR    = 5'd8;
    localparam logic [4:0] ALU_AND   = 5'd9;
    localparam logic [4:0] ALU_PASSB = 5'd10;
    localparam logic [4:0] ALU_MUL   = 5'd16;

    localparam logic [2:0] IMM_I = 3'd0;
    localparam logic [2:0] IMM_S = 3'd1;
    localparam logic [2:0] IMM_B = 3'd2;
    localparam logic [2:0] IMM_J = 3'd3;
    localparam logic [2:0] IMM_U = 3'd4;

    localparam logic [1:0] WB_ALU = 2'd0;
    localparam logic [1:0] WB_MEM = 2'd1;
    localparam logic [1:0] WB_PC4 = 2'd2;

    typedef struct packed {
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
        logic [2:0] imm_sel;
        logic [4:0] alu_ctrl;
        logic       op_a;
        logic       op_b;
        logic       reg_write;
        logic [1:0] mem_to_reg;
        logic       mem_read;
        logic       mem_write;
        logic [2:0] mem_size;
        logic       branch;
        logic       jal;
        logic       jalr;
        logic       lui;
        logic       auipc;
        logic [2:0] br_func;
        logic       illegal;
    } ctrl_t;

    function automatic logic [4:0] alu_of(input logic [2:0] f3, input logic alt);
        return f3 == 3'd0 ? (alt ? ALU_SUB : ALU_ADD) :
               f3 == 3'd1 ? ALU_SLL :
               f3 == 3'd2 ? ALU_SLT :
               f3 == 3'd3 ? ALU_SLTU :
               f3 == 3'd4 ? ALU_XOR :
               f3 == 3'd5 ? (alt ? ALU_SRA : ALU_SRL) :
               f3 == 3'd6 ? ALU_OR : ALU_AND;
    endfunction
endpackage

// File: rtl/rv32_decode_comb.sv
// rv32_decode_comb: combinational RV32I decode (instr_i -> ctrl_o, imm_o); RV32M_DECODE_EN adds M-extension decode
module rv32_decode_comb
    import rv32_ctrl_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     instr_i,
    output ctrl_t           ctrl_o,
    output logic [XLEN-1:0] imm_o
);
    logic [6:0]  opc, f7;
    logic [2:0]  f3;
    logic [31:0] i, imm32;
    ctrl_t       c;

    assign i   = instr_i;
    assign opc = i[6:0];
    assign f3  = i[14:12];
    assign f7  = i[31:25];

    always_comb begin
        c     = '0;
        c.rs1 = i[19:15];
        c.rs2 = i[24:20];
        c.rd  = i[11:7];
        case (opc)
            OPC_LUI: begin
                c.lui = 1'b1; c.alu_ctrl = ALU_PASSB; c.op_b = 1'b1; c.imm_sel = IMM_U; c.reg_write = 1'b1;
            end
            OPC_AUIPC: begin
                c.auipc = 1'b1; c.op_a = 1'b1; c.op_b = 1'b1; c.imm_sel = IMM_U; c.reg_write = 1'b1;
            end
            OPC_JAL: begin
                c.jal = 1'b1; c.op_a = 1'b1; c.op_b = 1'b1; c.imm_sel = IMM_J; c.reg_write = 1'b1;
                c.mem_to_reg = WB_PC4;
            end
            OPC_JALR: begin
                c.jalr = 1'b1; c.op_b = 1'b1; c.reg_write = 1'b1; c.mem_to_reg = WB_PC4;
                c.illegal = f3 != 3'd0;
            end
            OPC_BRANCH: begin
                c.branch = 1'b1; c.op_a = 1'b1; c.op_b = 1'b1; c.imm_sel = IMM_B; c.br_func = f3;
                c.illegal = f3[2:1] == 2'b01;
            end
            OPC_LOAD: begin
                c.mem_read = 1'b1; c.op_b = 1'b1; c.reg_write = 1'b1; c.mem_to_reg = WB_MEM; c.mem_size = f3;
                c.illegal = f3 == 3'd3 || f3[2:1] == 2'b11;
            end
            OPC_STORE: begin
                c.mem_write = 1'b1; c.op_b = 1'b1; c.imm_sel = IMM_S; c.mem_size = f3;
                c.illegal = f3 > 3'd2;
            end
            OPC_OPIMM: begin
                c.op_b = 1'b1; c.reg_write = 1'b1;
                c.alu_ctrl = alu_of(f3, f3 == 3'd5 && f7[5]);
                c.illegal = f3 == 3'd1 ? f7 != 7'h00 :
                            f3 == 3'd5 ? (f7 != 7'h00 && f7 != 7'h20) : 1'b0;
            end
            OPC_OP: begin
                c.reg_write = 1'b1;
                c.alu_ctrl = alu_of(f3, f7[5]);
                c.illegal = !(f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)));
`ifdef RV32M_DECODE_EN
                if (f7 == 7'h01) begin
                    c.alu_ctrl = ALU_MUL | {2'b00, f3};
                    c.illegal  = 1'b0;
                end
`endif
            end
            OPC_FENCE: c.illegal = 1'b0;
            default:   c.illegal = 1'b1;
        endcase
        if (c.illegal) begin
            c.reg_write = 1'b0; c.mem_read = 1'b0; c.mem_write = 1'b0;
            c.branch    = 1'b0; c.jal      = 1'b0; c.jalr      = 1'b0;
        end
        if (c.rd == 5'd0) c.reg_write = 1'b0;
        imm32 = c.imm_sel == IMM_S ? {{20{i[31]}}, i[31:25], i[11:7]} :
                c.imm_sel == IMM_B ? {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0} :
                c.imm_sel == IMM_J ? {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0} :
                c.imm_sel == IMM_U ? {i[31:12], 12'b0} :
                                     {{20{i[31]}}, i[31:20]};
    end

    assign ctrl_o = c;
    assign imm_o  = XLEN'($signed(imm32));
endmodule

// File: rtl/rv32_decode_stage.sv
// rv32_decode_stage: RV32I decode stage, in_* handshake -> decoder -> 2-entry skid buffer -> out_*; RV32M_DECODE_EN enables M decode
module rv32_decode_stage
    import rv32_ctrl_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int PC_W  = 32,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [PC_W-1:0]  in_pc,
    input  logic [TAG_W-1:0] in_tag,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [PC_W-1:0]  out_pc,
    output logic [TAG_W-1:0] out_tag,
    output logic [4:0]       out_rs1,
    output logic [4:0]       out_rs2,
    output logic [4:0]       out_rd,
    output logic [XLEN-1:0]  out_imm,
    output logic [2:0]       out_imm_sel,
    output logic [4:0]       out_alu_ctrl,
    output logic             out_op_a,
    output logic             out_op_b,
    output logic             out_reg_write,
    output logic [1:0]       out_mem_to_reg,
    output logic             out_mem_read,
    output logic             out_mem_write,
    output logic [2:0]       out_mem_size,
    output logic             out_branch,
    output logic             out_jal,
    output logic             out_jalr,
    output logic             out_lui,
    output logic             out_auipc,
    output logic [2:0]       out_br_func,
    output logic             out_illegal
);
    typedef struct packed {
        ctrl_t            c;
        logic [XLEN-1:0]  imm;
        logic [PC_W-1:0]  pc;
        logic [TAG_W-1:0] tag;
    } ent_t;

    localparam logic [1:0] S_EMPTY = 2'd0;
    localparam logic [1:0] S_ONE   = 2'd1;
    localparam logic [1:0] S_TWO   = 2'd2;

    logic [1:0]      state_q, state_d;
    ent_t            e0_q, e0_d, e1_q, e1_d, in_e;
    ctrl_t           dec_c;
    logic [XLEN-1:0] dec_imm;
    logic            acc, drn;

    rv32_decode_comb #(.XLEN(XLEN)) u_dec (
        .instr_i (in_instr),
        .ctrl_o  (dec_c),
        .imm_o   (dec_imm)
    );

    assign in_e      = {dec_c, dec_imm, in_pc, in_tag};
    assign in_ready  = state_q != S_TWO;
    assign out_valid = state_q != S_EMPTY;
    assign acc       = in_valid && in_ready;
    assign drn       = out_valid && out_ready;

    // e0 is always the head; e1 only fills when the head is stalled
    always_comb begin
        state_d = state_q;
        e0_d    = e0_q;
        e1_d    = e1_q;
        if (flush) state_d = S_EMPTY;
        else case (state_q)
            S_EMPTY: if (acc) begin e0_d = in_e; state_d = S_ONE; end
            S_ONE: begin
                if (acc && drn) e0_d = in_e;
                else if (acc) begin e1_d = in_e; state_d = S_TWO; end
                else if (drn) state_d = S_EMPTY;
            end
            S_TWO:   if (drn) begin e0_d = e1_q; state_d = S_ONE; end
            default: state_d = S_EMPTY;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_EMPTY;
            e0_q    <= '0;
            e1_q    <= '0;
        end else begin
            state_q <= state_d;
            e0_q    <= e0_d;
            e1_q    <= e1_d;
        end
    end

    assign out_pc         = e0_q.pc;
    assign out_tag        = e0_q.tag;
    assign out_imm        = e0_q.imm;
    assign out_rs1        = e0_q.c.rs1;
    assign out_rs2        = e0_q.c.rs2;
    assign out_rd         = e0_q.c.rd;
    assign out_imm_sel    = e0_q.c.imm_sel;
    assign out_alu_ctrl   = e0_q.c.alu_ctrl;
    assign out_op_a       = e0_q.c.op_a;
    assign out_op_b       = e0_q.c.op_b;
    assign out_reg_write  = e0_q.c.reg_write;
    assign out_mem_to_reg = e0_q.c.mem_to_reg;
    assign out_mem_read   = e0_q.c.mem_read;
    assign out_mem_write  = e0_q.c.mem_write;
    assign out_mem_size   = e0_q.c.mem_size;
    assign out_branch     = e0_q.c.branch;
    assign out_jal        = e0_q.c.jal;
    assign out_jalr       = e0_q.c.jalr;
    assign out_lui        = e0_q.c.lui;
    assign out_auipc      = e0_q.c.auipc;
    assign out_br_func    = e0_q.c.br_func;
    assign out_illegal    = e0_q.c.illegal;
endmodule

// File: tb/tb_rv32_decode_stage.sv
// tb_rv32_decode_stage: scoreboard bench for rv32_decode_stage with directed decode, backpressure, flush and reset cases
module tb_rv32_decode_stage;
    logic        clk = 1'b0, rst, in_valid, in_ready, flush, out_valid, out_ready;
    logic [31:0] in_instr, in_pc, out_pc, out_imm;
    logic [3:0]  in_tag, out_tag;
    logic [4:0]  out_rs1, out_rs2, out_rd, out_alu_ctrl;
    logic [2:0]  out_imm_sel, out_mem_size, out_br_func;
    logic [1:0]  out_mem_to_reg;
    logic        out_op_a, out_op_b, out_reg_write, out_mem_read, out_mem_write;
    logic        out_branch, out_jal, out_jalr, out_lui, out_auipc, out_illegal;
    logic [109:0] obus, hbus;
    logic [8:0]  oflg;
    bit          hv, done;
    int          checks = 0, fails = 0;

    typedef struct {
        logic [31:0] i;
        logic [4:0]  a;
        bit          ca;
        logic [8:0]  f;
        logic [1:0]  m;
        logic [2:0]  s;
        logic [31:0] imm;
        bit          ci;
        logic [14:0] r;
        bit          cr;
        logic [31:0] pc;
        logic [3:0]  tag;
    } vec_t;

    vec_t vt[$];
    vec_t sb[$];

    always #5 clk = ~clk;

    rv32_decode_stage dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
        .in_pc(in_pc), .in_tag(in_tag), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_tag(out_tag), .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd),
        .out_imm(out_imm), .out_imm_sel(out_imm_sel), .out_alu_ctrl(out_alu_ctrl), .out_op_a(out_op_a),
        .out_op_b(out_op_b), .out_reg_write(out_reg_write), .out_mem_to_reg(out_mem_to_reg),
        .out_mem_read(out_mem_read), .out_mem_write(out_mem_write), .out_mem_size(out_mem_size),
        .out_branch(out_branch), .out_jal(out_jal), .out_jalr(out_jalr), .out_lui(out_lui),
        .out_auipc(out_auipc), .out_br_func(out_br_func), .out_illegal(out_illegal)
    );

    assign oflg = {out_reg_write, out_mem_read, out_mem_write, out_branch, out_jal, out_jalr, out_illegal, out_op_a, out_op_b};
    assign obus = {out_pc, out_tag, out_imm, out_rs1, out_rs2, out_rd, out_imm_sel, out_alu_ctrl, oflg,
                   out_mem_to_reg, out_mem_size, out_br_func, out_lui, out_auipc};

    task automatic chk(input string n, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", n, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [31:0] i, input logic [4:0] a, input bit ca, input logic [8:0] f,
                                input logic [1:0] m, input logic [2:0] s, input logic [31:0] imm, input bit ci,
                                input logic [14:0] r, input bit cr);
        vec_t v;
        v = '{i:i, a:a, ca:ca, f:f, m:m, s:s, imm:imm, ci:ci, r:r, cr:cr, pc:32'h0, tag:4'h0};
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int k);
        vec_t e;
        bit   rdy, ok;
        e     = vt[k];
        e.pc  = 32'h1000 + 32'(k * 4);
        e.tag = 4'(k);
        in_valid = 1'b1;
        in_instr = e.i;
        in_pc    = e.pc;
        in_tag   = e.tag;
        ok = 1'b0;
        for (int n = 0; n < 50 && !ok; n++) begin
            @(negedge clk);
            rdy = in_ready;
            @(posedge clk);
            if (rdy) begin
                sb.push_back(e);
                ok = 1'b1;
            end
        end
        if (!ok) begin
            checks++;
            fails++;
            $display("FAIL accept_timeout: beat %0d got no in_ready required in_ready=1", k);
        end
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int n = 0; n < 40 && sb.size() != 0; n++) @(posedge clk);
        #1;
        chk("drain", 128'(sb.size()), 128'(0));
    endtask

    always @(negedge clk) begin
        vec_t       e;
        logic [8:0] msk;
        if (hv && out_valid) chk("hold", 128'(obus), 128'(hbus));
        hv   = out_valid && !out_ready && !rst;
        hbus = obus;
        if (!rst && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                checks++;
                fails++;
                $display("FAIL unexpected_beat: got pc %h required no beat", out_pc);
            end else begin
                e   = sb.pop_front();
                msk = e.f[2] ? 9'h1fc : 9'h1ff;
                chk("flags", 128'(oflg & msk), 128'(e.f & msk));
                if (!e.f[2]) chk("wb_sel", 128'(out_mem_to_reg), 128'(e.m));
                if (e.ca) chk("alu", 128'(out_alu_ctrl), 128'(e.a));
                if (e.ci) chk("imm", 128'({out_imm_sel, out_imm}), 128'({e.s, e.imm}));
                if (e.cr) chk("regs", 128'({out_rs1, out_rs2, out_rd}), 128'(e.r));
                chk("pc_tag", 128'({out_pc, out_tag}), 128'({e.pc, e.tag}));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test required finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
        in_instr = '0; in_pc = '0; in_tag = '0;
        vt.push_back(mk(32'h002081B3, 5'd0,  1, 9'b100000000, 2'd0, 3'd0, 32'h0,        0, {5'd1, 5'd2, 5'd3}, 1));
        vt.push_back(mk(32'h402081B3, 5'd1,  1, 9'b100000000, 2'd0, 3'd0, 32'h0,        0, {5'd1, 5'd2, 5'd3}, 1));
        vt.push_back(mk(32'h0020A423, 5'd0,  1, 9'b001000001, 2'd0, 3'd1, 32'h8,        1, 15'd0, 0));
`ifdef RV32M_DECODE_EN
        vt.push_back(mk(32'h022081B3, 5'd16, 1, 9'b100000000, 2'd0, 3'd0, 32'h0,        0, {5'd1, 5'd2, 5'd3}, 1));
`else
        vt.push_back(mk(32'h022081B3, 5'd0,  0, 9'b000000100, 2'd0, 3'd0, 32'h0,        0, 15'd0, 0));
`endif
        vt.push_back(mk(32'hFFF00293, 5'd0,  1, 9'b100000001, 2'd0, 3'd0, 32'hFFFFFFFF, 1, 15'd0, 0));
        vt.push_back(mk(32'h123450B7, 5'd10, 1, 9'b100000001, 2'd0, 3'd4, 32'h12345000, 1, 15'd0, 0));
        vt.push_back(mk(32'h00208863, 5'd0,  1, 9'b000100011, 2'd0, 3'd2, 32'h10,       1, 15'd0, 0));
        vt.push_back(mk(32'h008000EF, 5'd0,  1, 9'b100010011, 2'd2, 3'd3, 32'h8,        1, 15'd0, 0));
        vt.push_back(mk(32'hFFC12283, 5'd0,  1, 9'b110000001, 2'd1, 3'd0, 32'hFFFFFFFC, 1, 15'd0, 0));
        vt.push_back(mk(32'h0000B283, 5'd0,  0, 9'b000000100, 2'd0, 3'd0, 32'h0,        0, 15'd0, 0));
        vt.push_back(mk(32'h00000073, 5'd0,  0, 9'b000000100, 2'd0, 3'd0, 32'h0,        0, 15'd0, 0));
        vt.push_back(mk(32'h0FF0000F, 5'd0,  0, 9'b000000000, 2'd0, 3'd0, 32'h0,        0, 15'd0, 0));
        vt.push_back(mk(32'h40209093, 5'd0,  0, 9'b000000100, 2'd0, 3'd0, 32'h0,        0, 15'd0, 0));
        vt.push_back(mk(32'h4020D093, 5'd7,  1, 9'b100000001, 2'd0, 3'd0, 32'h0,        0, 15'd0, 0));
        vt.push_back(mk(32'h00208033, 5'd0,  1, 9'b000000000, 2'd0, 3'd0, 32'h0,        0, {5'd1, 5'd2, 5'd0}, 1));
        vt.push_back(mk(32'h402091B3, 5'd0,  0, 9'b000000100, 2'd0, 3'd0, 32'h0,        0, 15'd0, 0));
        vt.push_back(mk(32'h000100E7, 5'd0,  1, 9'b100001001, 2'd2, 3'd0, 32'h0,        1, 15'd0, 0));
        vt.push_back(mk(32'h000110E7, 5'd0,  0, 9'b000000100, 2'd0, 3'd0, 32'h0,        0, 15'd0, 0));
        vt.push_back(mk(32'h0020C1B3, 5'd5,  1, 9'b100000000, 2'd0, 3'd0, 32'h0,        0, {5'd1, 5'd2, 5'd3}, 1));
        vt.push_back(mk(32'h0020F1B3, 5'd9,  1, 9'b100000000, 2'd0, 3'd0, 32'h0,        0, {5'd1, 5'd2, 5'd3}, 1));
        vt.push_back(mk(32'h0020B1B3, 5'd4,  1, 9'b100000000, 2'd0, 3'd0, 32'h0,        0, {5'd1, 5'd2, 5'd3}, 1));
        #2;
        chk("rst_out_valid", 128'(out_valid), 128'(0));
        chk("rst_in_ready", 128'(in_ready), 128'(1));
        chk("rst_fields", 128'(obus), 128'(0));
        @(posedge clk);
        tick();
        rst = 1'b0;
        for (int k = 0; k < vt.size(); k++) send(k);
        drain();
        tick();
        out_ready = 1'b0;
        done = 1'b0;
        fork
            begin
                send(0);
                send(1);
                send(2);
                done = 1'b1;
            end
        join_none
        repeat (5) @(negedge clk);
        chk("bp_in_ready", 128'(in_ready), 128'(0));
        chk("bp_accepted", 128'(sb.size()), 128'(2));
        tick();
        out_ready = 1'b1;
        for (int n = 0; n < 100 && !done; n++) @(posedge clk);
        chk("bp_done", 128'(done), 128'(1));
        drain();
        tick();
        out_ready = 1'b0;
        send(3);
        send(4);
        in_valid = 1'b1;
        in_instr = vt[5].i;
        in_pc    = 32'hDEAD0000;
        in_tag   = 4'hF;
        flush    = 1'b1;
        @(posedge clk);
        sb.delete();
        #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("flush_out_valid", 128'(out_valid), 128'(0));
        chk("flush_in_ready", 128'(in_ready), 128'(1));
        out_ready = 1'b1;
        send(6);
        drain();
        tick();
        out_ready = 1'b0;
        send(7);
        send(8);
        #2;
        rst = 1'b1;
        #1;
        chk("rst_mid_out_valid", 128'(out_valid), 128'(0));
        chk("rst_mid_in_ready", 128'(in_ready), 128'(1));
        chk("rst_mid_fields", 128'(obus), 128'(0));
        sb.delete();
        tick();
        rst = 1'b0;
        out_ready = 1'b1;
        send(9);
        chk("post_rst_latency", 128'(out_valid), 128'(1));
        send(13);
        drain();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
